// File: rtl/fprint_comparator_pkg.sv
// Shared types and widths for the fingerprint comparator (package fprint_comp_pkg).
// Build option FPRINT_COMP_TMR_EN selects three-core operation.
`ifndef CRC_KEY_WIDTH
`define CRC_KEY_WIDTH 4
`endif
`ifndef CRC_RAM_ADDRESS_WIDTH
`define CRC_RAM_ADDRESS_WIDTH 8
`endif
`ifndef CRC_WIDTH
`define CRC_WIDTH 16
`endif

package fprint_comp_pkg;
  localparam int KEY_W  = `CRC_KEY_WIDTH;
  localparam int ADDR_W = `CRC_RAM_ADDRESS_WIDTH;
  localparam int DATA_W = `CRC_WIDTH;

`ifdef FPRINT_COMP_TMR_EN
  localparam int N_CORES = 3;
`else
  localparam int N_CORES = 2;
`endif
  // RD sub-step on which the last fingerprint word is captured
  localparam logic [1:0] RD_LAST = 2'(N_CORES);

  // Core 0 shares code 0 with FAULT_NONE; result_pass tells them apart.
  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_CORE0 = 2'd0;
  localparam logic [1:0] FAULT_CORE1 = 2'd1;
  localparam logic [1:0] FAULT_CORE2 = 2'd2;
  localparam logic [1:0] FAULT_UNK   = 2'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    CMP     = 3'd2,
    INC     = 3'd3,
    SETTLE  = 3'd4,
    REPORT  = 3'd5,
    RST_REQ = 3'd6
  } comp_state_e;
endpackage

// File: rtl/fprint_comparator_if.sv
// Bus bundle between the fingerprint comparator and its task/RAM/tail environment.
interface fprint_comparator_if #(
  parameter int CNT_W = 4
);
  import fprint_comp_pkg::*;

  logic              check_req;
  logic [KEY_W-1:0]  check_task_id;
  logic [CNT_W-1:0]  check_count;
  logic              check_ready;
  logic [KEY_W-1:0]  comparator_task_id;
  logic              comparator_inc_tail_pointer;
  logic              comp_inc_tail_pointer_ack;
  logic              comp_reset_task;
  logic [ADDR_W-1:0] comp_tail_pointer_0;
  logic [ADDR_W-1:0] comp_tail_pointer_1;
  logic [ADDR_W-1:0] comp_tail_pointer_2;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              result_valid;
  logic              result_pass;
  logic [1:0]        result_fault_core;
  logic [CNT_W-1:0]  result_index;

  modport master (
    input  check_req, check_task_id, check_count, comp_inc_tail_pointer_ack,
           comp_tail_pointer_0, comp_tail_pointer_1, comp_tail_pointer_2, ram_rdata,
    output check_ready, comparator_task_id, comparator_inc_tail_pointer, comp_reset_task,
           ram_rd, ram_addr, result_valid, result_pass, result_fault_core, result_index
  );

  modport slave (
    output check_req, check_task_id, check_count, comp_inc_tail_pointer_ack,
           comp_tail_pointer_0, comp_tail_pointer_1, comp_tail_pointer_2, ram_rdata,
    input  check_ready, comparator_task_id, comparator_inc_tail_pointer, comp_reset_task,
           ram_rd, ram_addr, result_valid, result_pass, result_fault_core, result_index
  );
endinterface

// File: rtl/fprint_comparator_vote.sv
// Combinational 2- or 3-way fingerprint vote with faulty-core selection (FPRINT_COMP_TMR_EN).
module fprint_vote
  import fprint_comp_pkg::*;
(
  input  logic [DATA_W-1:0] w0,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] w2,
  output logic              match,
  output logic [1:0]        fault_core
);
  logic e01_s;
  assign e01_s = (w0 == w1);

`ifdef FPRINT_COMP_TMR_EN
  logic e02_s;
  logic e12_s;
  assign e02_s = (w0 == w2);
  assign e12_s = (w1 == w2);

  // The odd one out is the core disagreeing with an agreeing pair
  always_comb begin
    match      = 1'b0;
    fault_core = FAULT_UNK;
    if (e01_s && e12_s) begin
      match      = 1'b1;
      fault_core = FAULT_NONE;
    end else if (e12_s) begin
      fault_core = FAULT_CORE0;
    end else if (e02_s) begin
      fault_core = FAULT_CORE1;
    end else if (e01_s) begin
      fault_core = FAULT_CORE2;
    end else begin
      fault_core = FAULT_UNK;
    end
  end
`else
  logic unused_w2_s;
  assign unused_w2_s = ^w2;

  // With two cores a mismatch cannot be attributed
  always_comb begin
    match      = 1'b0;
    fault_core = FAULT_UNK;
    if (e01_s) begin
      match      = 1'b1;
      fault_core = FAULT_NONE;
    end else begin
      match      = 1'b0;
      fault_core = FAULT_UNK;
    end
  end
`endif
endmodule

// File: rtl/fprint_comparator.sv
// Fingerprint comparator: reads one entry per core, votes, and advances tail pointers.
// Build option FPRINT_COMP_TMR_EN adds core 2 to the read and the vote.
module fprint_comparator
  import fprint_comp_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 comp_reset_task_ack,
  fprint_comparator_if.master bus
);
  comp_state_e       state_r, state_nx;
  logic [KEY_W-1:0]  task_id_r;
  logic [CNT_W-1:0]  count_r, idx_r, idx_inc_s;
  logic [1:0]        rd_cnt_r, rd_cnt_nx;
  logic [DATA_W-1:0] w0_r, w1_r, w2_s;
  logic [ADDR_W-1:0] tail_sel_s;
  logic              vote_match_s;
  logic [1:0]        vote_fault_s;

  logic              check_ready_r, ram_rd_r, inc_r, reset_task_r, valid_r, pass_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [1:0]        fault_r;
  logic [CNT_W-1:0]  index_r;
  logic              check_ready_s, ram_rd_s, inc_s, reset_task_s, valid_s, pass_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [1:0]        fault_s;
  logic [CNT_W-1:0]  index_s;

`ifdef FPRINT_COMP_TMR_EN
  logic [DATA_W-1:0] w2_r;
  assign w2_s = w2_r;
`else
  logic unused_tail2_s;
  assign w2_s           = {DATA_W{1'b0}};
  assign unused_tail2_s = ^bus.comp_tail_pointer_2;
`endif

  assign idx_inc_s = idx_r + {{(CNT_W-1){1'b0}}, 1'b1};

  fprint_vote u_vote (
    .w0        (w0_r),
    .w1        (w1_r),
    .w2        (w2_s),
    .match     (vote_match_s),
    .fault_core(vote_fault_s)
  );

  // State register
  always_ff @(posedge clk or posedge comp_reset_task_ack) begin
    if (comp_reset_task_ack) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    if (bus.check_req) state_nx = (bus.check_count == {CNT_W{1'b0}}) ? REPORT : RD;
               else state_nx = IDLE;
      RD:      if (rd_cnt_r == RD_LAST) state_nx = CMP;
               else state_nx = RD;
      CMP:     if (vote_match_s) state_nx = INC;
               else state_nx = REPORT;
      INC:     if (bus.comp_inc_tail_pointer_ack) state_nx = SETTLE;
               else state_nx = INC;
      SETTLE:  if (idx_inc_s == count_r) state_nx = REPORT;
               else state_nx = RD;
      REPORT:  state_nx = RST_REQ;
      RST_REQ: state_nx = RST_REQ;
      default: state_nx = IDLE;
    endcase
  end

  // Read sub-step sequencing and tail selection for the upcoming read
  always_comb begin
    rd_cnt_nx  = 2'd0;
    tail_sel_s = bus.comp_tail_pointer_0;
    if (state_r == RD && rd_cnt_r != RD_LAST) rd_cnt_nx = rd_cnt_r + 2'd1;
    else rd_cnt_nx = 2'd0;
    case (rd_cnt_nx)
      2'd0:    tail_sel_s = bus.comp_tail_pointer_0;
      2'd1:    tail_sel_s = bus.comp_tail_pointer_1;
`ifdef FPRINT_COMP_TMR_EN
      2'd2:    tail_sel_s = bus.comp_tail_pointer_2;
`endif
      default: tail_sel_s = bus.comp_tail_pointer_0;
    endcase
  end

  // Task latch, entry index and fingerprint capture
  always_ff @(posedge clk or posedge comp_reset_task_ack) begin
    if (comp_reset_task_ack) begin
      task_id_r <= {KEY_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      idx_r     <= {CNT_W{1'b0}};
      rd_cnt_r  <= 2'd0;
      w0_r      <= {DATA_W{1'b0}};
      w1_r      <= {DATA_W{1'b0}};
`ifdef FPRINT_COMP_TMR_EN
      w2_r      <= {DATA_W{1'b0}};
`endif
    end else begin
      rd_cnt_r <= rd_cnt_nx;
      case (state_r)
        IDLE: if (bus.check_req) begin
          task_id_r <= bus.check_task_id;
          count_r   <= bus.check_count;
          idx_r     <= {CNT_W{1'b0}};
        end
        // Word k arrives the cycle after read k, i.e. on sub-step k+1
        RD: case (rd_cnt_r)
          2'd1:    w0_r <= bus.ram_rdata;
          2'd2:    w1_r <= bus.ram_rdata;
`ifdef FPRINT_COMP_TMR_EN
          2'd3:    w2_r <= bus.ram_rdata;
`endif
          default: ;
        endcase
        SETTLE:  idx_r <= idx_inc_s;
        default: ;
      endcase
    end
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    check_ready_s = (state_nx == IDLE);
    ram_rd_s      = (state_nx == RD) && (rd_cnt_nx != RD_LAST);
    ram_addr_s    = ram_rd_s ? tail_sel_s : {ADDR_W{1'b0}};
    inc_s         = (state_nx == INC);
    reset_task_s  = (state_nx == RST_REQ);
    valid_s       = (state_nx == REPORT);
    pass_s        = pass_r;
    fault_s       = fault_r;
    index_s       = index_r;
    if (state_r == CMP && !vote_match_s) begin
      pass_s  = 1'b0;
      fault_s = vote_fault_s;
      index_s = idx_r;
    end else if (state_nx == REPORT && state_r != REPORT) begin
      pass_s  = 1'b1;
      fault_s = FAULT_NONE;
      index_s = {CNT_W{1'b0}};
    end else begin
      pass_s  = pass_r;
      fault_s = fault_r;
      index_s = index_r;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge comp_reset_task_ack) begin
    if (comp_reset_task_ack) begin
      check_ready_r <= 1'b1;
      ram_rd_r      <= 1'b0;
      ram_addr_r    <= {ADDR_W{1'b0}};
      inc_r         <= 1'b0;
      reset_task_r  <= 1'b0;
      valid_r       <= 1'b0;
      pass_r        <= 1'b0;
      fault_r       <= 2'd0;
      index_r       <= {CNT_W{1'b0}};
    end else begin
      check_ready_r <= check_ready_s;
      ram_rd_r      <= ram_rd_s;
      ram_addr_r    <= ram_addr_s;
      inc_r         <= inc_s;
      reset_task_r  <= reset_task_s;
      valid_r       <= valid_s;
      pass_r        <= pass_s;
      fault_r       <= fault_s;
      index_r       <= index_s;
    end
  end

  assign bus.check_ready                 = check_ready_r;
  assign bus.comparator_task_id          = task_id_r;
  assign bus.comparator_inc_tail_pointer = inc_r;
  assign bus.comp_reset_task             = reset_task_r;
  assign bus.ram_rd                      = ram_rd_r;
  assign bus.ram_addr                    = ram_addr_r;
  assign bus.result_valid                = valid_r;
  assign bus.result_pass                 = pass_r;
  assign bus.result_fault_core           = fault_r;
  assign bus.result_index                = index_r;
endmodule

// File: tb/tb_fprint_comparator.sv
// Directed bench for fprint_comparator with RAM, tail-pointer and ack models.
module tb_fprint_comparator;
  import fprint_comp_pkg::*;

  localparam int CW    = 4;
  localparam int BASE0 = 60;
  localparam int BASE1 = 70;
  localparam int BASE2 = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fprint_comparator_if #(.CNT_W(CW)) bus ();
  fprint_comparator #(.CNT_W(CW)) dut (.clk(clk), .comp_reset_task_ack(rst), .bus(bus));

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   rd_total  = 0;
  int   ack_total = 0;
  int   t2_hits   = 0;
  int   ack_base  = 0;
  logic ack_hold  = 1'b0;

  // Upstream owns the tails: each acknowledged increment advances all of them
  assign bus.comp_tail_pointer_0 = ADDR_W'(BASE0 + ack_total - ack_base);
  assign bus.comp_tail_pointer_1 = ADDR_W'(BASE1 + ack_total - ack_base);
  assign bus.comp_tail_pointer_2 = ADDR_W'(BASE2 + ack_total - ack_base);

  always @(posedge clk) begin
    if (bus.ram_rd) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      rd_total      <= rd_total + 1;
`ifndef FPRINT_COMP_TMR_EN
      if (bus.ram_addr == bus.comp_tail_pointer_2) t2_hits <= t2_hits + 1;
`endif
    end else begin
      bus.ram_rdata <= '0;
    end
  end

  always @(posedge clk) begin
    if (bus.comparator_inc_tail_pointer && !bus.comp_inc_tail_pointer_ack && !ack_hold) begin
      bus.comp_inc_tail_pointer_ack <= 1'b1;
      ack_total                     <= ack_total + 1;
    end else begin
      bus.comp_inc_tail_pointer_ack <= 1'b0;
    end
  end

  task automatic expect_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input int i);
    return DATA_W'(32'h0000_C3A0 + i * 7);
  endfunction

  task automatic fill(input int cnt, input int bad, input int mask);
    logic [DATA_W-1:0] v;
    int base_k;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = '0;
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < N_CORES; k++) begin
        base_k = (k == 0) ? BASE0 : ((k == 1) ? BASE1 : BASE2);
        v = pat(i);
        if (i == bad && mask[k]) v = v ^ DATA_W'(32'h0100 << k);
        mem[base_k + i] = v;
      end
    end
  endtask

  task automatic pulse_reset(input string nm);
    rst = 1'b1;
    #1;
    expect_eq({nm, "_rst_reset_task"}, bus.comp_reset_task, 0);
    expect_eq({nm, "_rst_inc"}, bus.comparator_inc_tail_pointer, 0);
    expect_eq({nm, "_rst_ram_rd"}, bus.ram_rd, 0);
    expect_eq({nm, "_rst_valid"}, bus.result_valid, 0);
    expect_eq({nm, "_rst_task_id"}, bus.comparator_task_id, 0);
    @(negedge clk);
    rst      = 1'b0;
    ack_hold = 1'b0;
    ack_base = ack_total;
    @(negedge clk);
    expect_eq({nm, "_ready_after_rst"}, bus.check_ready, 1);
    expect_eq({nm, "_no_restart"}, bus.ram_rd, 0);
  endtask

  task automatic run_row(input string nm, input int cnt, input int bad, input int mask,
                         input int efault, input logic [KEY_W-1:0] tid);
    int r0, a0, cyc;
    bit pass_exp;
    pass_exp = (mask == 0);
    fill(cnt, bad, mask);
    r0 = rd_total;
    a0 = ack_total;
    bus.check_task_id = tid;
    bus.check_count   = CW'(cnt);
    bus.check_req     = 1'b1;
    @(negedge clk);
    bus.check_task_id = ~tid;
    bus.check_count   = CW'(1);
    cyc = 0;
    while (!bus.result_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    bus.check_req = 1'b0;
    expect_eq({nm, "_valid"}, bus.result_valid, 1);
    expect_eq({nm, "_pass"}, bus.result_pass, int'(pass_exp));
    expect_eq({nm, "_task_id"}, bus.comparator_task_id, tid);
    expect_eq({nm, "_reads"}, rd_total - r0, N_CORES * (pass_exp ? cnt : bad + 1));
    expect_eq({nm, "_acks"}, ack_total - a0, pass_exp ? cnt : bad);
    if (!pass_exp) begin
      expect_eq({nm, "_fault"}, bus.result_fault_core, efault);
      expect_eq({nm, "_index"}, bus.result_index, bad);
    end
    @(negedge clk);
    expect_eq({nm, "_valid_1cyc"}, bus.result_valid, 0);
    expect_eq({nm, "_reset_req"}, bus.comp_reset_task, 1);
    pulse_reset(nm);
  endtask

  initial begin
    int r0, a0, cyc, held;
    bus.check_req     = 1'b0;
    bus.check_task_id = '0;
    bus.check_count   = '0;
    repeat (3) @(negedge clk);
    expect_eq("init_ready", bus.check_ready, 1);
    expect_eq("init_ram_rd", bus.ram_rd, 0);
    expect_eq("init_inc", bus.comparator_inc_tail_pointer, 0);
    expect_eq("init_reset_task", bus.comp_reset_task, 0);
    expect_eq("init_valid", bus.result_valid, 0);
    rst = 1'b0;
    @(negedge clk);
    expect_eq("init_ready_rel", bus.check_ready, 1);

`ifdef FPRINT_COMP_TMR_EN
    run_row("tmr_eq3", 3, 0, 0, 0, 4'd2);
    run_row("tmr_c1e2", 4, 2, 3'b010, 1, 4'd1);
    run_row("tmr_alld", 2, 0, 3'b111, 3, 4'd3);
    run_row("tmr_c0e1", 3, 1, 3'b001, 0, 4'd4);
    run_row("tmr_c2e1", 2, 1, 3'b100, 2, 4'd5);
`else
    run_row("dmr_eq2", 2, 0, 0, 0, 4'd2);
    expect_eq("dmr_tail2_unused", t2_hits, 0);
    run_row("dmr_c1e2", 4, 2, 2'b10, 3, 4'd1);
    run_row("dmr_c0e0", 3, 0, 2'b01, 3, 4'd3);
    run_row("dmr_eq1", 1, 0, 0, 0, 4'd6);
`endif

    // Zero-length check reports straight away without touching the RAM
    r0 = rd_total;
    bus.check_task_id = 4'd7;
    bus.check_count   = '0;
    bus.check_req     = 1'b1;
    cyc = 0;
    while (!bus.result_valid && cyc < 2) begin
      @(negedge clk);
      cyc++;
    end
    bus.check_req = 1'b0;
    expect_eq("cnt0_valid", bus.result_valid, 1);
    expect_eq("cnt0_pass", bus.result_pass, 1);
    expect_eq("cnt0_reads", rd_total - r0, 0);
    @(negedge clk);
    expect_eq("cnt0_reset_req", bus.comp_reset_task, 1);
    pulse_reset("cnt0");

    // Withheld ack: the increment request must stay up until reset
    fill(1, 0, 0);
    a0 = ack_total;
    ack_hold          = 1'b1;
    bus.check_task_id = 4'd9;
    bus.check_count   = CW'(1);
    bus.check_req     = 1'b1;
    @(negedge clk);
    bus.check_req = 1'b0;
    cyc = 0;
    while (!bus.comparator_inc_tail_pointer && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    expect_eq("hold_inc_raised", bus.comparator_inc_tail_pointer, 1);
    held = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.comparator_inc_tail_pointer) held++;
    end
    expect_eq("hold_inc_20cyc", held, 20);
    expect_eq("hold_no_ack", ack_total - a0, 0);
    pulse_reset("hold");
    expect_eq("hold_pass_zero", bus.result_pass, 0);
    expect_eq("hold_fault_zero", bus.result_fault_core, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fprint_comparator.md
FPRINT_COMPARATOR -- requirements
Module: fprint_comparator

Interface
REQ-001 Parameter CNT_W, default 4, width of per-core fingerprint count.
REQ-002 clk  input  1  clock, rising edge.
REQ-003 comp_reset_task_ack  input  1  reset, asynchronous, active-high.
REQ-004 check_req  input  1  request to check one task.
REQ-005 check_task_id  input  `CRC_KEY_WIDTH  task to check.
REQ-006 check_count  input  CNT_W  fingerprints per core to compare.
REQ-007 check_ready  output  1  high only in IDLE.
REQ-008 comparator_task_id  output  `CRC_KEY_WIDTH  task selecting tail pointers.
REQ-009 comparator_inc_tail_pointer  output  1  tail increment request.
REQ-010 comp_inc_tail_pointer_ack  input  1  tail increment acknowledge.
REQ-011 comp_reset_task  output  1  task pointer reset request.
REQ-012 comp_tail_pointer_0  input  `CRC_RAM_ADDRESS_WIDTH  core 0 tail.
REQ-013 comp_tail_pointer_1  input  `CRC_RAM_ADDRESS_WIDTH  core 1 tail.
REQ-014 comp_tail_pointer_2  input  `CRC_RAM_ADDRESS_WIDTH  core 2 tail.
REQ-015 ram_rd / ram_addr  output  1 / `CRC_RAM_ADDRESS_WIDTH  fingerprint RAM read strobe and address.
REQ-016 ram_rdata  input  `CRC_WIDTH  read data, valid exactly one cycle after ram_rd.
REQ-017 result_valid / result_pass  output  1 / 1  one-cycle result pulse and verdict.
REQ-018 result_fault_core / result_index  output  2 / CNT_W  faulty core (3 = undetermined), failing entry index.

Function
REQ-019 States SHALL be IDLE, RD, CMP, INC, SETTLE, REPORT, RST_REQ.
REQ-020 IDLE: check_req high latches task id and count, drives comparator_task_id, enters RD; index cleared to 0.
REQ-021 check_req while check_ready low SHALL be ignored and not queued.
REQ-022 check_count = 0 SHALL go IDLE -> REPORT with result_pass=1, no RAM reads.
REQ-023 RD: one ram_rd per active core, consecutive cycles, addresses = current tail of core 0,1(,2); each data word registered the cycle after its read.
REQ-024 CMP: cycle after last capture; equal entries -> INC; mismatch -> REPORT with result_pass=0, result_index=current index, no tail increment.
REQ-025 INC: comparator_inc_tail_pointer held high until ack sampled high, dropped next edge; ack absent SHALL hold indefinitely.
REQ-026 SETTLE: one cycle after ack before tails re-sampled; index+1; index = check_count -> REPORT, else RD.
REQ-027 Tail wrap-around is owned upstream; block SHALL use presented tail values unmodified.
REQ-028 REPORT: result_valid high exactly one cycle, result fields stable that cycle, then RST_REQ.
REQ-029 RST_REQ: comp_reset_task high until comp_reset_task_ack, whose assertion returns block to IDLE.
REQ-030 Read-to-read latency per entry SHALL be N+1 cycles (N active cores) plus CMP, INC handshake, SETTLE.

Reset
REQ-031 comp_reset_task_ack high SHALL immediately force IDLE, abandon any in-flight read or tail request, and zero every output except check_ready (1 after release).
REQ-032 Reset mid-handshake SHALL drop comparator_inc_tail_pointer without waiting for ack.

Configuration
REQ-033 FPRINT_COMP_TMR_EN defined: three cores read and compared; single disagreeing core -> result_fault_core = its id, all differ -> 3.
REQ-034 FPRINT_COMP_TMR_EN undefined: cores 0,1 only, comp_tail_pointer_2 ignored, any mismatch -> result_fault_core = 3.

Structure
REQ-035 Package fprint_comp_pkg SHALL hold state enum, fault-code constants (FAULT_NONE=0..FAULT_UNK=3) and width aliases of crc_defines macros.
REQ-036 Sub-module fprint_vote SHALL perform 2- or 3-way compare and faulty-core selection, combinational.

Verification
REQ-037 TMR, task 2, count 3, tails 60/70/80, all RAM equal -> 9 reads, 3 tail acks, result_pass=1, comp_reset_task asserted.
REQ-038 TMR, task 1, count 4, entry 2 core 1 corrupted -> result_pass=0, result_index=2, result_fault_core=1, exactly 2 tail increments.
REQ-039 TMR, all three words differ at entry 0 -> result_fault_core=3, zero tail increments.
REQ-040 count 0 -> result_valid within 2 cycles, result_pass=1, no ram_rd.
REQ-041 Ack withheld 20 cycles, then reset pulse -> increment request held 20 cycles, all outputs 0 after reset, check_ready=1.
REQ-042 Without FPRINT_COMP_TMR_EN, count 2, equal data -> 4 reads only, ram_addr never equals comp_tail_pointer_2.
